commit_sequencer: RTL and testbench
===================================

# commit_sequencer

In-order tag allocator and retirement sequencer that owns the register file's rename/commit port. It hands out tags to dispatch, collects completed results, and retires them in program order onto the register-file write port. On a mispredicted retirement it drives the global clear pulse and the PC redirect.

## Interface
Parameters:
- DEPTH, 15, number of in-flight entries; tags are 1..DEPTH, tag 0 means "no dependency".
- TAG_W, 4, tag width; must satisfy 2^TAG_W > DEPTH.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global enable; when 0, no state changes at the edge.
- alloc_req  in  1  dispatch requests one entry this cycle.
- alloc_has_rd  in  1  instruction writes a destination register.
- alloc_rd  in  5  destination register index.
- alloc_pc  in  32  instruction PC.
- next_tag  out  TAG_W  tag the next accepted alloc receives (combinational from tail).
- full  out  1  no alloc accepted this cycle (count==DEPTH, or state FLUSH).
- cdb_valid  in  1  a result is broadcast.
- cdb_tag  in  TAG_W  tag of the result.
- cdb_val  in  32  result value.
- cdb_mispredict  in  1  result is a mispredicted control transfer.
- cdb_target  in  32  correct next PC when cdb_mispredict=1.
- now_tag  out  TAG_W  tag at head (registered pointer).
- write_rdy  out  1  register-file write strobe, one cycle per retirement.
- rd  out  5  register written.
- write_val  out  32  value written.
- clear  out  1  flush pulse to register file and all stations.
- redirect_valid  out  1  fetch redirect pulse.
- redirect_pc  out  32  redirect target.
- commit_pulse  out  1  one cycle per retired instruction.
- commit_pc  out  32  PC of the retired instruction.

## Operation
- Entry fields: busy, ready, has_rd, rd, val, pc, mispredict, target. Head and tail pointers hold tag values in 1..DEPTH; increment wraps DEPTH -> 1. count is 0..DEPTH.
- States: RUN, FLUSH. Reset -> RUN.
- Alloc (RUN, rdy_in=1, alloc_req=1, full=0): the entry at tail gets busy=1, ready=0 and the dispatch fields; tail advances. An alloc while full=1 is dropped. Dispatch must hold its request.
- Completion (RUN, cdb_valid=1): if entry[cdb_tag] is busy, set ready=1 and store val, mispredict and target. A non-busy tag, or tag 0, is ignored.
- Retire (RUN): when the head entry is busy and ready, retire it at the edge. Free the entry, advance head, decrement count, and register write_rdy=has_rd, rd, write_val=val, commit_pulse=1, commit_pc=pc. At most one retirement per cycle.
- Mispredict retire: the normal retire outputs, plus clear=1, redirect_valid=1, redirect_pc=target. All entries are freed, head=tail=1, count=0, and the state moves to FLUSH.
- FLUSH: lasts exactly one cycle. Alloc and cdb are ignored and full=1. Then RUN.
- Simultaneous alloc and retire: count is unchanged. When count==DEPTH, a same-cycle retire does not admit an alloc, because full is evaluated before the edge.
- Pulse outputs (write_rdy, commit_pulse, clear, redirect_valid) return to 0 at the next edge unless re-fired. With rdy_in=0 they are cleared and nothing else changes.

## Timing
- Reset values: write_rdy=0, commit_pulse=0, clear=0, redirect_valid=0, rd=0, write_val=0, redirect_pc=0, commit_pc=0, now_tag=1, next_tag=1, full=0, count=0, all entries not busy.
- Alloc to tag visibility: next_tag is valid in the same cycle as the request. The entry becomes busy at that cycle's edge.
- Completion to retirement: ready is set at edge N. The earliest retirement decision is at edge N+1, and the write strobe is visible in the cycle after edge N+1. There is no same-cycle bypass from the cdb to retirement.
- Retirement outputs are registered. When write_rdy=1, now_tag already equals the retired tag+1 (wrapped).
- clear is high for exactly one cycle, which is also the FLUSH cycle. The first alloc after a flush gets tag 1 and is accepted in the cycle after clear.
- Reset asserted mid-operation clears everything immediately, including any pulse in flight.

## Test plan
- Reset, then 3 allocs with rd=5,6,7 -> next_tag reads 1,2,3. Completing them in order 3,1,2 with vals 30,10,20 -> write_rdy pulses in order rd=5/10, 6/20, 7/30, with now_tag 2,3,4.
- Fill 15 entries -> full=1 and a 16th alloc is dropped. Complete and retire tag 1 -> full drops the cycle after the retire, and the next alloc gets tag 1 (wrap).
- Allocate tags 1..4 and complete tag 2 with cdb_mispredict=1, target=0x100, then complete tag 1 -> tag 1 retires, then tag 2 retires with clear=1, redirect_valid=1, redirect_pc=0x100. Completion of tags 3 and 4 is ignored. The next alloc gets tag 1 one cycle after clear.
- alloc_has_rd=0 (store) -> commit_pulse=1 with write_rdy=0.
- Hold rdy_in=0 for 5 cycles while alloc_req, cdb_valid and a ready head are all present -> no pointer, count or output change and the pulses stay 0. The same head retires on the first cycle with rdy_in=1.
- Assert rst_in asynchronously during a clear cycle -> all outputs go to their reset values immediately, and now_tag=1.

Source files
------------

// File: rtl/commit_sequencer.sv
// commit_sequencer
//
// In-order tag allocator and retirement sequencer. It owns the rename/commit
// port of the register file. Dispatch receives tags 1..DEPTH in program order.
// Completed results arrive on the CDB and are marked ready. The head entry
// retires onto the register-file write port, with at most one retirement per
// cycle. A mispredicted retirement flushes every entry, pulses clear and the
// fetch redirect, and spends one cycle in FLUSH.
//
// Ports
//   clk_in, rst_in     clock, asynchronous active-high reset
//   rdy_in             global enable; when low, only the pulse outputs change (they drop)
//   alloc_*            dispatch request and its destination/PC fields
//   next_tag, full     tag the next accepted alloc gets; alloc blocked
//   cdb_*              result broadcast (tag, value, mispredict, target)
//   now_tag            tag at the head
//   write_rdy, rd, write_val            register-file write port (registered)
//   clear, redirect_valid, redirect_pc  flush and fetch redirect (registered)
//   commit_pulse, commit_pc             retirement trace (registered)

module commit_sequencer #(
  parameter int DEPTH = 15,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             alloc_req,
  input  logic             alloc_has_rd,
  input  logic [4:0]       alloc_rd,
  input  logic [31:0]      alloc_pc,
  output logic [TAG_W-1:0] next_tag,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  input  logic             cdb_mispredict,
  input  logic [31:0]      cdb_target,
  output logic [TAG_W-1:0] now_tag,
  output logic             write_rdy,
  output logic [4:0]       rd,
  output logic [31:0]      write_val,
  output logic             clear,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             commit_pulse,
  output logic [31:0]      commit_pc
);

  localparam logic [TAG_W-1:0] DEPTH_TAG = TAG_W'(DEPTH);
  localparam logic [TAG_W-1:0] ONE_TAG   = TAG_W'(1);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // Pointers hold tag values (1..DEPTH), not array indices.
  logic [TAG_W-1:0] head_reg, tail_reg, count_reg;

  logic             write_rdy_reg, commit_pulse_reg, clear_reg, redirect_valid_reg;
  logic [4:0]       rd_reg;
  logic [31:0]      write_val_reg, commit_pc_reg, redirect_pc_reg;

  // Flattened views of the per-entry storage, indexed by tag-1.
  logic [DEPTH-1:0]       busy_vec, ready_vec, has_rd_vec, mis_vec;
  logic [DEPTH-1:0][4:0]  rd_vec;
  logic [DEPTH-1:0][31:0] val_vec, pc_vec, target_vec;

  logic [TAG_W-1:0] head_idx, cdb_idx;
  logic             cdb_in_range;

  logic alloc_fire, cdb_fire, retire_fire, flush_fire;

  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] t);
    return (t == DEPTH_TAG) ? ONE_TAG : t + ONE_TAG;
  endfunction

  assign head_idx     = head_reg - ONE_TAG;
  assign cdb_idx      = cdb_tag - ONE_TAG;
  // Tag 0 means "no dependency". Tags above DEPTH name no entry.
  assign cdb_in_range = (cdb_tag != '0) && (cdb_tag <= DEPTH_TAG);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state and per-cycle action decode
  // ------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    full        = (count_reg == DEPTH_TAG) || (state_reg == FLUSH);
    alloc_fire  = 1'b0;
    cdb_fire    = 1'b0;
    retire_fire = 1'b0;
    flush_fire  = 1'b0;
    if (rdy_in) begin
      case (state_reg)
        RUN: begin
          // full is computed from pre-edge count. A retire in this cycle does
          // not free a slot for a same-cycle alloc.
          alloc_fire  = alloc_req && !full;
          cdb_fire    = cdb_valid && cdb_in_range && busy_vec[cdb_idx];
          // Retirement looks only at registered ready. There is no CDB bypass.
          retire_fire = busy_vec[head_idx] && ready_vec[head_idx];
          flush_fire  = retire_fire && mis_vec[head_idx];
          if (flush_fire) begin
            state_next = FLUSH;
          end
        end
        FLUSH: begin
          state_next = RUN;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Entry storage, one slot per tag
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [TAG_W-1:0] ENTRY_TAG = TAG_W'(gi + 1);

      logic        busy_reg, ready_reg, has_rd_reg, mis_reg;
      logic [4:0]  erd_reg;
      logic [31:0] val_reg, pc_reg, target_reg;
      logic        alloc_here, cdb_here, free_here;

      assign alloc_here = alloc_fire && (tail_reg == ENTRY_TAG);
      assign cdb_here   = cdb_fire && (cdb_tag == ENTRY_TAG);
      assign free_here  = flush_fire || (retire_fire && (head_reg == ENTRY_TAG));

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          busy_reg   <= 1'b0;
          ready_reg  <= 1'b0;
          has_rd_reg <= 1'b0;
          mis_reg    <= 1'b0;
          erd_reg    <= '0;
          val_reg    <= '0;
          pc_reg     <= '0;
          target_reg <= '0;
        end else if (free_here) begin
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end else if (alloc_here) begin
          // The tail slot is never busy when alloc fires, so this cannot
          // coincide with a completion for the same slot.
          busy_reg   <= 1'b1;
          ready_reg  <= 1'b0;
          has_rd_reg <= alloc_has_rd;
          erd_reg    <= alloc_rd;
          pc_reg     <= alloc_pc;
          mis_reg    <= 1'b0;
        end else if (cdb_here) begin
          ready_reg  <= 1'b1;
          val_reg    <= cdb_val;
          mis_reg    <= cdb_mispredict;
          target_reg <= cdb_target;
        end
      end

      assign busy_vec[gi]   = busy_reg;
      assign ready_vec[gi]  = ready_reg;
      assign has_rd_vec[gi] = has_rd_reg;
      assign mis_vec[gi]    = mis_reg;
      assign rd_vec[gi]     = erd_reg;
      assign val_vec[gi]    = val_reg;
      assign pc_vec[gi]     = pc_reg;
      assign target_vec[gi] = target_reg;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Pointers, occupancy and registered retirement outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_reg           <= ONE_TAG;
      tail_reg           <= ONE_TAG;
      count_reg          <= '0;
      write_rdy_reg      <= 1'b0;
      commit_pulse_reg   <= 1'b0;
      clear_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      rd_reg             <= '0;
      write_val_reg      <= '0;
      commit_pc_reg      <= '0;
      redirect_pc_reg    <= '0;
    end else begin
      // Pulses drop every edge unless re-fired. This includes edges with rdy_in=0.
      write_rdy_reg      <= 1'b0;
      commit_pulse_reg   <= 1'b0;
      clear_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;

      if (flush_fire) begin
        head_reg  <= ONE_TAG;
        tail_reg  <= ONE_TAG;
        count_reg <= '0;
      end else begin
        if (retire_fire) head_reg <= tag_inc(head_reg);
        if (alloc_fire)  tail_reg <= tag_inc(tail_reg);
        count_reg <= count_reg + {{(TAG_W-1){1'b0}}, alloc_fire}
                               - {{(TAG_W-1){1'b0}}, retire_fire};
      end

      if (retire_fire) begin
        write_rdy_reg    <= has_rd_vec[head_idx];
        rd_reg           <= rd_vec[head_idx];
        write_val_reg    <= val_vec[head_idx];
        commit_pulse_reg <= 1'b1;
        commit_pc_reg    <= pc_vec[head_idx];
      end

      if (flush_fire) begin
        clear_reg          <= 1'b1;
        redirect_valid_reg <= 1'b1;
        redirect_pc_reg    <= target_vec[head_idx];
      end
    end
  end

  assign next_tag       = tail_reg;
  assign now_tag        = head_reg;
  assign write_rdy      = write_rdy_reg;
  assign rd             = rd_reg;
  assign write_val      = write_val_reg;
  assign commit_pulse   = commit_pulse_reg;
  assign commit_pc      = commit_pc_reg;
  assign clear          = clear_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

endmodule

// File: tb/tb_commit_sequencer.sv
// tb_commit_sequencer
//
// Drives directed scenarios and then a randomized phase into commit_sequencer.
// Every cycle is compared against a queue-based program-order model of the
// in-flight window. The model keeps the oldest instruction at the front of a
// queue. Tags follow from the head tag plus the queue position, so the model
// has no array slots or pointer registers.

module tb_commit_sequencer;

  localparam int DEPTH = 15;
  localparam int TAG_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b1;
  logic             rdy_in = 1'b0;
  logic             alloc_req = 1'b0;
  logic             alloc_has_rd = 1'b0;
  logic [4:0]       alloc_rd = '0;
  logic [31:0]      alloc_pc = '0;
  logic [TAG_W-1:0] next_tag;
  logic             full;
  logic             cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [31:0]      cdb_val = '0;
  logic             cdb_mispredict = 1'b0;
  logic [31:0]      cdb_target = '0;
  logic [TAG_W-1:0] now_tag;
  logic             write_rdy;
  logic [4:0]       rd;
  logic [31:0]      write_val;
  logic             clear;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             commit_pulse;
  logic [31:0]      commit_pc;

  commit_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_req(alloc_req), .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .next_tag(next_tag), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .now_tag(now_tag), .write_rdy(write_rdy), .rd(rd), .write_val(write_val),
    .clear(clear), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .commit_pulse(commit_pulse), .commit_pc(commit_pc)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  typedef struct {
    int          tag;
    logic        has_rd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        done;
    logic [31:0] val;
    logic        mis;
    logic [31:0] tgt;
  } ent_t;

  ent_t        rob[$];
  int          m_head = 1;
  bit          m_flush = 0;
  logic        e_write_rdy, e_commit, e_clear, e_redir;
  logic [4:0]  e_rd;
  logic [31:0] e_wval, e_cpc, e_rpc;

  int n_vec = 0;
  int n_err = 0;

  function automatic int wrap(input int t);
    return ((t - 1) % DEPTH) + 1;
  endfunction

  function automatic int m_tail();
    return wrap(m_head + rob.size());
  endfunction

  task automatic model_reset();
    rob.delete();
    m_head = 1;
    m_flush = 0;
    e_write_rdy = 0; e_commit = 0; e_clear = 0; e_redir = 0;
    e_rd = '0; e_wval = '0; e_cpc = '0; e_rpc = '0;
  endtask

  // Apply one clock edge to the model, using the inputs present before the edge.
  task automatic model_edge();
    bit   full_pre, ret;
    ent_t old;
    ent_t ne;
    if (!rdy_in) begin
      e_write_rdy = 0; e_commit = 0; e_clear = 0; e_redir = 0;
      return;
    end
    e_write_rdy = 0; e_commit = 0; e_clear = 0; e_redir = 0;
    if (m_flush) begin
      m_flush = 0;
      return;
    end
    full_pre = (rob.size() == DEPTH);
    ret = (rob.size() > 0) && rob[0].done;
    if (ret) old = rob[0];
    if (cdb_valid) begin
      foreach (rob[i]) begin
        if (rob[i].tag == int'(cdb_tag)) begin
          rob[i].done = 1;
          rob[i].val  = cdb_val;
          rob[i].mis  = cdb_mispredict;
          rob[i].tgt  = cdb_target;
        end
      end
    end
    if (ret) begin
      void'(rob.pop_front());
      m_head = wrap(m_head + 1);
      e_write_rdy = old.has_rd;
      e_rd = old.rd;
      e_wval = old.val;
      e_commit = 1;
      e_cpc = old.pc;
    end
    if (alloc_req && !full_pre) begin
      ne.tag = m_tail(); ne.has_rd = alloc_has_rd; ne.rd = alloc_rd; ne.pc = alloc_pc;
      ne.done = 0; ne.val = '0; ne.mis = 0; ne.tgt = '0;
      rob.push_back(ne);
    end
    if (ret && old.mis) begin
      rob.delete();
      m_head = 1;
      m_flush = 1;
      e_clear = 1;
      e_redir = 1;
      e_rpc = old.tgt;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("now_tag", 32'(now_tag), 32'(m_head));
    chk("next_tag", 32'(next_tag), 32'(m_tail()));
    chk("full", 32'(full), 32'((rob.size() == DEPTH) || m_flush));
    chk("write_rdy", 32'(write_rdy), 32'(e_write_rdy));
    chk("rd", 32'(rd), 32'(e_rd));
    chk("write_val", write_val, e_wval);
    chk("commit_pulse", 32'(commit_pulse), 32'(e_commit));
    chk("commit_pc", commit_pc, e_cpc);
    chk("clear", 32'(clear), 32'(e_clear));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_redir));
    chk("redirect_pc", redirect_pc, e_rpc);
  endtask

  // One clock: the model steps on the current inputs, then the DUT is sampled 1ns after the edge.
  task automatic cyc();
    model_edge();
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  task automatic idle();
    alloc_req = 0; cdb_valid = 0; cdb_mispredict = 0; rdy_in = 1;
  endtask

  task automatic do_alloc(input logic has, input logic [4:0] r, input logic [31:0] pc);
    idle();
    alloc_req = 1; alloc_has_rd = has; alloc_rd = r; alloc_pc = pc;
    cyc();
    idle();
  endtask

  task automatic do_cdb(input int tag, input logic [31:0] v, input logic mis, input logic [31:0] tgt);
    idle();
    cdb_valid = 1; cdb_tag = TAG_W'(tag); cdb_val = v; cdb_mispredict = mis; cdb_target = tgt;
    cyc();
    idle();
  endtask

  task automatic do_reset();
    rst_in = 1;
    #2;
    model_reset();
    check_all();
    @(posedge clk_in);
    #1;
    rst_in = 0;
    check_all();
  endtask

  initial begin
    model_reset();
    @(posedge clk_in);
    #1;
    idle();
    do_reset();

    // In-order retirement of out-of-order completions.
    chk("first_next_tag", 32'(next_tag), 32'd1);
    do_alloc(1, 5'd5, 32'h1000);
    do_alloc(1, 5'd6, 32'h1004);
    do_alloc(1, 5'd7, 32'h1008);
    do_cdb(3, 32'd30, 0, 0);
    do_cdb(1, 32'd10, 0, 0);
    do_cdb(2, 32'd20, 0, 0);
    for (int i = 0; i < 4; i++) cyc();
    chk("now_tag_after_three", 32'(now_tag), 32'd4);

    // Fill the window, drop the 16th alloc, free tag 1, then wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_alloc(1, 5'(i + 1), 32'h2000 + 32'(4 * i));
    chk("full_at_depth", 32'(full), 32'd1);
    do_alloc(1, 5'd31, 32'hdead);
    do_cdb(1, 32'h11, 0, 0);
    cyc();
    do_alloc(1, 5'd20, 32'h3000);
    for (int t = 2; t <= DEPTH; t++) do_cdb(t, 32'(t * 3), 0, 0);
    do_cdb(1, 32'h77, 0, 0);
    for (int i = 0; i < 4; i++) cyc();

    // Mispredict flush with late completions that must be ignored.
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(1, 5'(i + 8), 32'h4000 + 32'(4 * i));
    do_cdb(2, 32'h22, 1, 32'h100);
    do_cdb(1, 32'h21, 0, 0);
    cyc();
    cyc();
    chk("redirect_pc_0x100", redirect_pc, 32'h100);
    alloc_req = 1; alloc_has_rd = 1; alloc_rd = 5'd3; alloc_pc = 32'h5000;
    cdb_valid = 1; cdb_tag = 4'd3; cdb_val = 32'h33; cdb_mispredict = 0;
    cyc();
    cdb_tag = 4'd4; cdb_val = 32'h44;
    cyc();
    idle();
    cyc();

    // Store: commit without a register write.
    do_reset();
    do_alloc(0, 5'd9, 32'h6000);
    do_cdb(1, 32'h99, 0, 0);
    cyc();
    cyc();

    // rdy_in low freezes everything while a ready head waits.
    do_alloc(1, 5'd12, 32'h7000);
    do_cdb(2, 32'hab, 0, 0);
    rdy_in = 0; alloc_req = 1; alloc_rd = 5'd13; cdb_valid = 1; cdb_tag = 4'd2;
    for (int i = 0; i < 5; i++) cyc();
    idle();
    cyc();
    cyc();

    // Asynchronous reset during the clear cycle.
    do_alloc(1, 5'd14, 32'h8000);
    do_cdb(3, 32'hcd, 1, 32'h200);
    cyc();
    chk("clear_before_rst", 32'(clear), 32'd1);
    do_reset();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      rdy_in = ($urandom % 8) != 0;
      alloc_req = ($urandom % 3) != 0;
      alloc_has_rd = ($urandom % 4) != 0;
      alloc_rd = 5'($urandom);
      alloc_pc = $urandom;
      cdb_valid = ($urandom % 2) == 0;
      if (rob.size() > 0 && ($urandom % 4) != 0)
        cdb_tag = TAG_W'(rob[$urandom % rob.size()].tag);
      else
        cdb_tag = TAG_W'($urandom % 16);
      cdb_val = $urandom;
      cdb_mispredict = ($urandom % 12) == 0;
      cdb_target = $urandom;
      cyc();
    end
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
